rgmii_rx_delay_tuner: RTL and testbench
=======================================

# rgmii_rx_delay_tuner

Runtime calibration controller for the RGMII receive path: sweeps a shared IDELAYE2 tap value (VAR_LOAD mode) across all RX data/ctl lanes, scores each tap from the MAC's frame-status pulses, and loads the centre of the widest error-free window. It replaces compile-time fixed data delays on boards with differing PHY RXDLY behaviour. It sits beside the 1G RGMII MAC wrapper: its inputs are MAC status strobes, and its outputs drive the IDELAY CNTVALUEIN/LD pins.

## Interface
Parameters:
- TAP_WIDTH, 5, IDELAY counter width; taps swept are 0..2^TAP_WIDTH-1
- DEFAULT_TAP, 25, tap used at reset and on calibration failure
- SETTLE_CYCLES, 64, wait after each load before scoring
- DWELL_FRAMES, 16, good frames required for a tap to pass
- TIMEOUT_CYCLES, 2^20, maximum scoring time per tap
- MIN_WINDOW, 4, minimum passing run required to declare lock

Ports (one clock; reset is synchronous and active-high):
- clock125  in  1  125 MHz clock, also the IDELAYE2 C pin clock
- reset  in  1  synchronous, active-high
- start  in  1  pulse; begins a sweep when idle
- rx_good_frame  in  1  MAC good-frame strobe
- rx_bad_fcs  in  1  MAC FCS-error strobe
- rx_bad_frame  in  1  MAC bad-frame strobe
- tap_value  out  TAP_WIDTH  to CNTVALUEIN of every data/ctl IDELAY
- tap_load  out  1  to LD; one-cycle pulse
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end
- locked  out  1  last sweep found a window of at least MIN_WINDOW
- window_lo, window_hi  out  TAP_WIDTH each  bounds of the chosen window

## Operation
- States: INIT, IDLE, LOAD, SETTLE, SCORE, EVAL, APPLY.
- INIT: the first cycle after reset issues tap_load with DEFAULT_TAP, then moves to IDLE.
- IDLE: start moves to LOAD with the sweep tap at 0 and the run tracker cleared. start is ignored in all other states.
- LOAD: drive tap_value to the sweep tap, pulse tap_load, then go to SETTLE.
- SETTLE: count SETTLE_CYCLES. Strobes are ignored. Go to SCORE.
- SCORE: count good frames (saturating at DWELL_FRAMES) and errors (bad_fcs OR bad_frame, saturating flag). Exit to EVAL when good reaches DWELL_FRAMES or the cycle count reaches TIMEOUT_CYCLES.
  - Simultaneous strobes in one cycle each count.
- EVAL: the tap passes if good equals DWELL_FRAMES and no error was seen.
  - A passing tap extends the current run. A failing tap closes it.
  - A closed run replaces the best run only if strictly longer, so the earliest run wins ties.
  - If the tap is the last tap, close the run and go to APPLY. Otherwise increment the tap and go to LOAD. No wrap-around.
- APPLY:
  - If best length is at least MIN_WINDOW: final = lo + ((hi-lo)>>1), floor; locked=1; window_lo/window_hi = best bounds.
  - Otherwise: final = DEFAULT_TAP, locked=0, window bounds = 0.
  - Then pulse tap_load with final, pulse done, return to IDLE.
- Run length uses TAP_WIDTH+1 bits, so a run of all 2^TAP_WIDTH taps is representable.

## Timing
- Reset values: tap_value=DEFAULT_TAP, tap_load=0, busy=0, done=0, locked=0, window_lo=0, window_hi=0. All outputs are registered.
- tap_value changes in the same cycle tap_load rises, and stays stable until the next load.
- busy rises the cycle after start is sampled, and falls in the same cycle done pulses.
- locked and window bounds update only in APPLY, and hold between sweeps.
- Per-tap latency: 1 (LOAD) + SETTLE_CYCLES + up to TIMEOUT_CYCLES + 1 (EVAL).
- Reset mid-sweep: abort immediately, apply reset values, and re-run INIT. No partial results are kept.

## Structure
- Shared header rgmii_tune_defs.vh: state encodings and default parameter constants. The board wrappers reuse the DEFAULT_TAP values from it.
- Sub-module rgmii_tune_window: a run/best-run tracker with inputs pass, valid, tap, and last, and outputs best_lo, best_hi, best_len.
- The IDELAYE2 instances stay in the board wrapper and are not part of this block.

## Test plan
- Reset, then idle 10 cycles: exactly one tap_load, with tap_value=25. busy=0, locked=0.
- Model passes taps 8..19 only, DWELL_FRAMES=16: done pulses, locked=1, window 8/19, final tap_load value 13.
- Two passing runs of equal length, 2..5 and 20..23: window 2/5, final tap 3.
- No good frames at any tap, TIMEOUT_CYCLES=1000: sweep ends after about 32×(1066) cycles, locked=0, final tap 25.
- Tap 10 receives 16 good frames plus one bad_fcs in the same cycle as a good frame: tap 10 fails and splits the run.
- start pulsed while busy: ignored. Reset asserted during SCORE at tap 7: next cycle busy=0 and tap_value=25, then one INIT tap_load follows.

Source files
------------

// File: rtl/rgmii_rx_delay_tuner_pkg.sv
// Shared definitions for the RGMII RX delay tuner: controller states and default constants.
// The board wrappers reuse DEF_DEFAULT_TAP from here.
package rgmii_rx_delay_tuner_pkg;

  localparam int DEF_TAP_WIDTH      = 5;
  localparam int DEF_DEFAULT_TAP    = 25;
  localparam int DEF_SETTLE_CYCLES  = 64;
  localparam int DEF_DWELL_FRAMES   = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1 << 20;
  localparam int DEF_MIN_WINDOW     = 4;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SCORE  = 3'd4,
    ST_EVAL   = 3'd5,
    ST_APPLY  = 3'd6
  } tune_state_t;

  // Floor centre of a window, written to avoid overflow of lo+hi.
  function automatic int window_centre(input int lo, input int hi);
    return lo + ((hi - lo) >>> 1);
  endfunction

endpackage

// File: rtl/rgmii_tune_window.sv
// Tracks the current run of passing taps and the longest closed run seen this sweep.
// Ties keep the earlier run because a closed run only replaces the best when strictly longer.
module rgmii_tune_window #(
  parameter int TAP_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 clear,
  input  logic                 valid,
  input  logic                 pass,
  input  logic                 last,
  input  logic [TAP_WIDTH-1:0] tap,
  output logic [TAP_WIDTH-1:0] best_lo,
  output logic [TAP_WIDTH-1:0] best_hi,
  output logic [TAP_WIDTH:0]   best_len
);

  logic [TAP_WIDTH-1:0] run_lo_reg, run_lo_next;
  logic [TAP_WIDTH:0]   run_len_reg, run_len_next;
  logic [TAP_WIDTH-1:0] best_lo_reg, best_lo_next;
  logic [TAP_WIDTH:0]   best_len_reg, best_len_next;
  logic [TAP_WIDTH-1:0] cand_lo;
  logic [TAP_WIDTH:0]   cand_len;

  always_comb begin
    run_lo_next   = run_lo_reg;
    run_len_next  = run_len_reg;
    best_lo_next  = best_lo_reg;
    best_len_next = best_len_reg;
    // The candidate is the run as it stands after this tap is folded in.
    cand_lo  = run_lo_reg;
    cand_len = run_len_reg;
    if (pass) begin
      cand_lo  = (run_len_reg == '0) ? tap : run_lo_reg;
      cand_len = run_len_reg + 1'b1;
    end
    if (clear) begin
      run_lo_next   = '0;
      run_len_next  = '0;
      best_lo_next  = '0;
      best_len_next = '0;
    end else if (valid) begin
      run_lo_next  = cand_lo;
      run_len_next = (pass && !last) ? cand_len : '0;
      if ((!pass || last) && (cand_len > best_len_reg)) begin
        best_lo_next  = cand_lo;
        best_len_next = cand_len;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      run_lo_reg   <= '0;
      run_len_reg  <= '0;
      best_lo_reg  <= '0;
      best_len_reg <= '0;
    end else begin
      run_lo_reg   <= run_lo_next;
      run_len_reg  <= run_len_next;
      best_lo_reg  <= best_lo_next;
      best_len_reg <= best_len_next;
    end
  end

  assign best_lo  = best_lo_reg;
  assign best_len = best_len_reg;
  assign best_hi  = best_lo_reg + TAP_WIDTH'(best_len_reg - 1'b1);

endmodule

// File: rtl/rgmii_rx_delay_tuner.sv
// Sweeps a shared IDELAY tap across all RX lanes, scores each tap from MAC frame strobes,
// and loads the centre of the widest error-free window (or the default tap on failure).
module rgmii_rx_delay_tuner
  import rgmii_rx_delay_tuner_pkg::*;
#(
  parameter int TAP_WIDTH      = DEF_TAP_WIDTH,
  parameter int DEFAULT_TAP    = DEF_DEFAULT_TAP,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int DWELL_FRAMES   = DEF_DWELL_FRAMES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MIN_WINDOW     = DEF_MIN_WINDOW
) (
  input  logic                 clock125,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 rx_good_frame,
  input  logic                 rx_bad_fcs,
  input  logic                 rx_bad_frame,
  output logic [TAP_WIDTH-1:0] tap_value,
  output logic                 tap_load,
  output logic                 busy,
  output logic                 done,
  output logic                 locked,
  output logic [TAP_WIDTH-1:0] window_lo,
  output logic [TAP_WIDTH-1:0] window_hi
);

  localparam int CNT_W  = $clog2(SETTLE_CYCLES + TIMEOUT_CYCLES + 1);
  localparam int GOOD_W = $clog2(DWELL_FRAMES + 1);
  localparam logic [TAP_WIDTH-1:0] LAST_TAP = '1;
  localparam logic [TAP_WIDTH-1:0] DEF_TAP  = TAP_WIDTH'(DEFAULT_TAP);

  tune_state_t          state_reg, state_next;
  logic [TAP_WIDTH-1:0] sweep_tap_reg, sweep_tap_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [GOOD_W-1:0]    good_reg, good_next;
  logic                 err_reg, err_next;
  logic [TAP_WIDTH-1:0] tap_value_reg, tap_value_next;
  logic                 tap_load_reg, tap_load_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 locked_reg, locked_next;
  logic [TAP_WIDTH-1:0] window_lo_reg, window_lo_next;
  logic [TAP_WIDTH-1:0] window_hi_reg, window_hi_next;

  logic                 win_clear, win_valid, win_pass, win_last;
  logic [TAP_WIDTH-1:0] best_lo, best_hi;
  logic [TAP_WIDTH:0]   best_len;

  rgmii_tune_window #(.TAP_WIDTH(TAP_WIDTH)) u_window (
    .clk      (clock125),
    .srst     (reset),
    .clear    (win_clear),
    .valid    (win_valid),
    .pass     (win_pass),
    .last     (win_last),
    .tap      (sweep_tap_reg),
    .best_lo  (best_lo),
    .best_hi  (best_hi),
    .best_len (best_len)
  );

  always_comb begin
    state_next     = state_reg;
    sweep_tap_next = sweep_tap_reg;
    cnt_next       = cnt_reg;
    good_next      = good_reg;
    err_next       = err_reg;
    tap_value_next = tap_value_reg;
    tap_load_next  = 1'b0;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    locked_next    = locked_reg;
    window_lo_next = window_lo_reg;
    window_hi_next = window_hi_reg;
    win_clear      = 1'b0;
    win_valid      = 1'b0;
    win_pass       = 1'b0;
    win_last       = 1'b0;
    case (state_reg)
      ST_INIT: begin
        tap_value_next = DEF_TAP;
        tap_load_next  = 1'b1;
        state_next     = ST_IDLE;
      end
      ST_IDLE: begin
        if (start) begin
          sweep_tap_next = '0;
          win_clear      = 1'b1;
          busy_next      = 1'b1;
          state_next     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tap_value_next = sweep_tap_reg;
        tap_load_next  = 1'b1;
        cnt_next       = '0;
        state_next     = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_reg == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_next   = '0;
          good_next  = '0;
          err_next   = 1'b0;
          state_next = ST_SCORE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_SCORE: begin
        // An error arriving alongside the final good frame still fails the tap.
        if (rx_good_frame && (good_reg != GOOD_W'(DWELL_FRAMES)))
          good_next = good_reg + 1'b1;
        err_next = err_reg | rx_bad_fcs | rx_bad_frame;
        cnt_next = cnt_reg + 1'b1;
        if ((good_next == GOOD_W'(DWELL_FRAMES)) || (cnt_next == CNT_W'(TIMEOUT_CYCLES)))
          state_next = ST_EVAL;
      end
      ST_EVAL: begin
        win_valid = 1'b1;
        win_pass  = (good_reg == GOOD_W'(DWELL_FRAMES)) && !err_reg;
        win_last  = (sweep_tap_reg == LAST_TAP);
        if (win_last) begin
          state_next = ST_APPLY;
        end else begin
          sweep_tap_next = sweep_tap_reg + 1'b1;
          state_next     = ST_LOAD;
        end
      end
      ST_APPLY: begin
        if (int'(best_len) >= MIN_WINDOW) begin
          tap_value_next = TAP_WIDTH'(window_centre(int'(best_lo), int'(best_hi)));
          locked_next    = 1'b1;
          window_lo_next = best_lo;
          window_hi_next = best_hi;
        end else begin
          tap_value_next = DEF_TAP;
          locked_next    = 1'b0;
          window_lo_next = '0;
          window_hi_next = '0;
        end
        tap_load_next = 1'b1;
        done_next     = 1'b1;
        busy_next     = 1'b0;
        state_next    = ST_IDLE;
      end
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clock125) begin
    if (reset) begin
      state_reg     <= ST_INIT;
      sweep_tap_reg <= '0;
      cnt_reg       <= '0;
      good_reg      <= '0;
      err_reg       <= 1'b0;
      tap_value_reg <= DEF_TAP;
      tap_load_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      locked_reg    <= 1'b0;
      window_lo_reg <= '0;
      window_hi_reg <= '0;
    end else begin
      state_reg     <= state_next;
      sweep_tap_reg <= sweep_tap_next;
      cnt_reg       <= cnt_next;
      good_reg      <= good_next;
      err_reg       <= err_next;
      tap_value_reg <= tap_value_next;
      tap_load_reg  <= tap_load_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      locked_reg    <= locked_next;
      window_lo_reg <= window_lo_next;
      window_hi_reg <= window_hi_next;
    end
  end

  assign tap_value = tap_value_reg;
  assign tap_load  = tap_load_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign locked    = locked_reg;
  assign window_lo = window_lo_reg;
  assign window_hi = window_hi_reg;

endmodule

// File: tb/tb_rgmii_rx_delay_tuner.sv
// Bench for rgmii_rx_delay_tuner: a per-tap link model drives MAC strobes, and the expected
// outcome of each sweep comes from an exhaustive search for the widest all-pass tap interval.
module tb_rgmii_rx_delay_tuner;

  localparam int TW      = 5;
  localparam int NT      = 32;
  localparam int DEF_TAP = 25;
  localparam int SETTLE  = 64;
  localparam int DWELL   = 16;
  localparam int TIMEOUT = 1000;
  localparam int MIN_WIN = 4;

  localparam int M_PASS   = 0;
  localparam int M_ERR    = 1;
  localparam int M_SILENT = 2;
  localparam int M_SPLIT  = 3;

  logic          clock125 = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          rx_good_frame = 1'b0;
  logic          rx_bad_fcs = 1'b0;
  logic          rx_bad_frame = 1'b0;
  logic [TW-1:0] tap_value, window_lo, window_hi;
  logic          tap_load, busy, done, locked;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int mode [NT];

  rgmii_rx_delay_tuner #(
    .TAP_WIDTH(TW), .DEFAULT_TAP(DEF_TAP), .SETTLE_CYCLES(SETTLE),
    .DWELL_FRAMES(DWELL), .TIMEOUT_CYCLES(TIMEOUT), .MIN_WINDOW(MIN_WIN)
  ) dut (
    .clock125(clock125), .reset(reset), .start(start),
    .rx_good_frame(rx_good_frame), .rx_bad_fcs(rx_bad_fcs), .rx_bad_frame(rx_bad_frame),
    .tap_value(tap_value), .tap_load(tap_load), .busy(busy), .done(done),
    .locked(locked), .window_lo(window_lo), .window_hi(window_hi)
  );

  always #4 clock125 = ~clock125;
  always @(posedge clock125) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Widest interval whose taps all pass; earliest interval wins among equals.
  task automatic model_sweep(output int exp_tap, output int exp_locked, output int exp_lo,
                             output int exp_hi);
    int best_lo = 0;
    int best_len = 0;
    for (int lo = 0; lo < NT; lo++) begin
      for (int hi = lo; hi < NT; hi++) begin
        bit all_pass = 1'b1;
        for (int t = lo; t <= hi; t++)
          if (mode[t] != M_PASS) all_pass = 1'b0;
        if (all_pass && (hi - lo + 1) > best_len) begin
          best_lo  = lo;
          best_len = hi - lo + 1;
        end
      end
    end
    if (best_len >= MIN_WIN) begin
      exp_lo = best_lo;
      exp_hi = best_lo + best_len - 1;
      exp_tap = (exp_lo + exp_hi) / 2;
      exp_locked = 1;
    end else begin
      exp_lo = 0;
      exp_hi = 0;
      exp_tap = DEF_TAP;
      exp_locked = 0;
    end
  endtask

  task automatic clear_strobes();
    rx_good_frame = 1'b0;
    rx_bad_fcs    = 1'b0;
    rx_bad_frame  = 1'b0;
  endtask

  task automatic wait_load(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock125);
      clear_strobes();
      if (tap_load === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic recover();
    reset = 1'b1;
    repeat (3) @(negedge clock125);
    reset = 1'b0;
    repeat (4) @(negedge clock125);
  endtask

  // Link behaviour for one tap: random junk while settling, then frames per the tap's mode.
  task automatic drive_tap(input int m, input bit poke_start);
    int err_at;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock125);
      rx_good_frame = 1'($urandom_range(0, 1));
      rx_bad_fcs    = ($urandom_range(0, 3) == 0);
      rx_bad_frame  = ($urandom_range(0, 3) == 0);
      start = poke_start && (i == 0);
    end
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock125);
      clear_strobes();
    end
    if (m == M_SILENT) return;
    err_at = (m == M_ERR) ? int'($urandom_range(0, DWELL - 1)) : (m == M_SPLIT) ? DWELL - 1 : -1;
    for (int g = 0; g < DWELL; g++) begin
      int gap = int'($urandom_range(0, 2));
      for (int k = 0; k < gap; k++) begin
        @(negedge clock125);
        clear_strobes();
      end
      @(negedge clock125);
      clear_strobes();
      rx_good_frame = 1'b1;
      if (g == err_at) begin
        if (m == M_SPLIT) rx_bad_fcs = 1'b1;
        else begin
          rx_bad_fcs   = 1'($urandom_range(0, 1));
          rx_bad_frame = !rx_bad_fcs || ($urandom_range(0, 1) == 1);
        end
      end
    end
  endtask

  task automatic run_sweep(input string name, input bit poke, output int elapsed);
    int exp_tap, exp_locked, exp_lo, exp_hi, c0;
    bit ok;
    elapsed = 0;
    model_sweep(exp_tap, exp_locked, exp_lo, exp_hi);
    @(negedge clock125);
    start = 1'b1;
    c0 = cyc;
    @(negedge clock125);
    start = 1'b0;
    check_val({name, "_busy_rise"}, busy, 1);
    for (int t = 0; t < NT; t++) begin
      wait_load(TIMEOUT + SETTLE + 300, ok);
      if (!ok) begin
        check_val({name, "_load_timeout"}, 0, 1);
        recover();
        return;
      end
      check_val({name, "_sweep_tap"}, tap_value, t);
      drive_tap(mode[t], poke && (t == 3));
    end
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT + 300; i++) begin
      @(negedge clock125);
      clear_strobes();
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check_val({name, "_done_timeout"}, 0, 1);
      recover();
      return;
    end
    elapsed = cyc - c0;
    check_val({name, "_final_load"}, tap_load, 1);
    check_val({name, "_final_tap"}, tap_value, exp_tap);
    check_val({name, "_locked"}, locked, exp_locked);
    check_val({name, "_window_lo"}, window_lo, exp_lo);
    check_val({name, "_window_hi"}, window_hi, exp_hi);
    check_val({name, "_busy_fall"}, busy, 0);
    $display("sweep %s: tap=%0d locked=%0d window=%0d..%0d (model tap=%0d locked=%0d window=%0d..%0d) cycles=%0d",
             name, tap_value, locked, window_lo, window_hi, exp_tap, exp_locked, exp_lo, exp_hi, elapsed);
  endtask

  task automatic count_loads(input string name);
    int n_loads = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock125);
      if (tap_load === 1'b1) n_loads++;
    end
    check_val({name, "_load_count"}, n_loads, 1);
    check_val({name, "_init_tap"}, tap_value, DEF_TAP);
    check_val({name, "_busy"}, busy, 0);
    check_val({name, "_locked"}, locked, 0);
    $display("init %s: loads=%0d tap=%0d busy=%0d locked=%0d", name, n_loads, tap_value, busy, locked);
  endtask

  initial begin
    int elapsed;
    bit ok;

    // Reset state, then the single INIT load.
    repeat (3) @(negedge clock125);
    check_val("rst_tap_value", tap_value, DEF_TAP);
    check_val("rst_tap_load", tap_load, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_locked", locked, 0);
    check_val("rst_window_lo", window_lo, 0);
    check_val("rst_window_hi", window_hi, 0);
    reset = 1'b0;
    count_loads("power_on");

    // Window 8..19.
    for (int t = 0; t < NT; t++) mode[t] = (t >= 8 && t <= 19) ? M_PASS : M_ERR;
    run_sweep("win_8_19", 1'b0, elapsed);
    repeat (20) @(negedge clock125);
    check_val("hold_locked", locked, 1);
    check_val("hold_window_lo", window_lo, 8);
    check_val("hold_window_hi", window_hi, 19);
    check_val("hold_tap_value", tap_value, 13);

    // Reset while scoring tap 7 aborts the sweep and clears the lock.
    for (int t = 0; t < NT; t++) mode[t] = M_SILENT;
    @(negedge clock125);
    start = 1'b1;
    @(negedge clock125);
    start = 1'b0;
    for (int t = 0; t <= 7; t++) begin
      wait_load(TIMEOUT + SETTLE + 300, ok);
      if (!ok) begin
        check_val("abort_load_timeout", 0, 1);
        break;
      end
    end
    check_val("abort_at_tap", tap_value, 7);
    repeat (SETTLE + 20) @(negedge clock125);
    reset = 1'b1;
    @(negedge clock125);
    check_val("abort_busy", busy, 0);
    check_val("abort_tap_value", tap_value, DEF_TAP);
    check_val("abort_tap_load", tap_load, 0);
    reset = 1'b0;
    count_loads("after_abort");

    // Equal-length runs: the earlier one wins.
    for (int t = 0; t < NT; t++)
      mode[t] = ((t >= 2 && t <= 5) || (t >= 20 && t <= 23)) ? M_PASS : M_ERR;
    run_sweep("tie_2_5", 1'b0, elapsed);

    // Tap 10 fails on an error coincident with its last good frame; start poked mid-sweep.
    for (int t = 0; t < NT; t++) mode[t] = (t >= 8 && t <= 19) ? M_PASS : M_ERR;
    mode[10] = M_SPLIT;
    run_sweep("split_10", 1'b1, elapsed);

    for (int r = 0; r < 2; r++) begin
      for (int t = 0; t < NT; t++) begin
        int v = int'($urandom_range(0, 15));
        mode[t] = (v < 11) ? M_PASS : (v < 15) ? M_ERR : M_SILENT;
      end
      run_sweep($sformatf("random_%0d", r), 1'b0, elapsed);
    end

    // No good frames anywhere: every tap times out.
    for (int t = 0; t < NT; t++) mode[t] = M_SILENT;
    run_sweep("all_timeout", 1'b0, elapsed);
    check_val("all_timeout_length_ok",
              (elapsed >= NT * (SETTLE + TIMEOUT + 2) - 4) && (elapsed <= NT * (SETTLE + TIMEOUT + 2) + 8), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
